alu_sequencer: RTL

- Command-side master for the 8-bit accumulator ALU.
- Accepts operation commands over a valid/ready handshake and drives the ALU's operand and selector inputs.
- Waits out the ALU's register latency, captures the ALU result, and returns it over a valid/ready result handshake.
- Keeps a shadow accumulator so chained operations are deterministic. The ALU's persist feedback path is never used.

---
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side master for the 8-bit accumulator ALU.
// Accepts commands over cmd_valid/cmd_ready, drives the ALU operand and
// selector inputs, waits out the ALU latency, captures the result into a
// shadow accumulator and returns it over res_valid/res_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_src, cmd_a, cmd_b
//   res_valid/ready     result handshake; res_data, res_err
//   alu_on              ALU power-on request
//   alu_in_sel          one-hot 001 persist, 010 load, 100 reset
//   alu_num1/2          ALU operands
//   alu_out_sel         one-hot AND,OR,NOT,XOR,ADD,SUB,MUL (bit0..bit6)
//   alu_result          ALU output value
//   alu_state           00 off, 01 ready, 10 run, 11 run_error
module alu_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_src,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_state
);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAKE,
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [2:0] SEL_LOAD  = 3'b010;
    localparam logic [2:0] SEL_RESET = 3'b100;
    localparam logic [6:0] OUT_AND   = 7'b0000001;
    localparam int         CW        = 16;

    state_t          state;
    logic [WIDTH-1:0] acc;
    logic            clr_q;
    logic [CW-1:0]   cnt;
    logic            alu_off;

    assign alu_off = (alu_state == 2'b00);

    // Command opcode to ALU output selector (note XOR/NOT bit swap).
    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        logic [6:0] sel;
        case (op)
            3'd0:    sel = 7'b0000001;
            3'd1:    sel = 7'b0000010;
            3'd2:    sel = 7'b0001000;
            3'd3:    sel = 7'b0000100;
            3'd4:    sel = 7'b0010000;
            3'd5:    sel = 7'b0100000;
            3'd6:    sel = 7'b1000000;
            default: sel = OUT_AND;
        endcase
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            acc         <= '0;
            clr_q       <= 1'b0;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            alu_on      <= 1'b0;
            alu_in_sel  <= SEL_RESET;
            alu_num1    <= '0;
            alu_num2    <= '0;
            alu_out_sel <= OUT_AND;
        end else begin
            unique case (state)
                S_OFF: begin
                    alu_on <= 1'b1;
                    state  <= S_WAKE;
                end
                S_WAKE: begin
                    if (alu_state == 2'b01) begin
                        state      <= S_IDLE;
                        cmd_ready  <= 1'b1;
                        alu_in_sel <= SEL_LOAD;
                        alu_num1   <= acc;
                        alu_num2   <= '0;
                    end
                end
                S_IDLE: begin
                    if (alu_off) begin
                        cmd_ready <= 1'b0;
                        state     <= S_WAKE;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        clr_q     <= (cmd_op == 3'd7);
                        state     <= S_ISSUE;
                        if (cmd_op == 3'd7) begin
                            alu_in_sel  <= SEL_RESET;
                            alu_out_sel <= OUT_AND;
                            alu_num1    <= '0;
                            alu_num2    <= '0;
                        end else begin
                            alu_in_sel  <= SEL_LOAD;
                            alu_num1    <= cmd_src ? cmd_a : acc;
                            alu_num2    <= cmd_b;
                            alu_out_sel <= op_onehot(cmd_op);
                        end
                    end
                end
                S_ISSUE: begin
                    if (alu_off) begin
                        state <= S_WAKE;
                    end else if (SETTLE <= 1) begin
                        state <= S_CAPTURE;
                    end else begin
                        // SETTLE state lasts cnt+1 = SETTLE-1 cycles
                        cnt   <= CW'(SETTLE - 2);
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (alu_off) begin
                        state <= S_WAKE;
                    end else if (cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (alu_off) begin
                        state <= S_WAKE;
                    end else begin
                        res_data  <= clr_q ? '0 : alu_result;
                        acc       <= clr_q ? '0 : alu_result;
                        res_err   <= (alu_state == 2'b11);
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= S_IDLE;
                        alu_in_sel <= SEL_LOAD;
                        alu_num1   <= acc;
                        alu_num2   <= '0;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

endmodule
